alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_ctrl_iter_counter.sv | 30 +++
 rtl/alu_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU controller and datapath.
package alu_pkg;

    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_DIV = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_iter_counter.sv
// Iteration counter for multi-cycle ALU operations; terminal count flags the last iteration.
module iter_counter #(
    parameter int W  = 64,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] r_cnt;

    assign cnt = r_cnt;
    assign tc  = (r_cnt == CW'(W - 1));

    // Explicit wrap at W-1 so non-power-of-two widths still count 0..W-1.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl.sv
// Moore sequencer for the ALU datapath: load, iterate (MUL/DIV), divide fix-up, result write.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int w = 64
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           op,
    output logic [3:0]           sel,
    output logic                 ld,
    output logic                 step_en,
    output logic                 fix_en,
    output logic                 res_we,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(w)-1:0] cnt,
    output logic [2:0]           dbg_state
);

    // Handshake: start is a request accepted only when the FSM is IDLE and abort
    // is low; there is no ready output, busy=1 means a request would be dropped.

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_op_q;
    logic       w_tc;
    logic       w_accept;
    logic       w_cnt_clear;
    logic       w_cnt_en;

    assign w_accept    = (r_state == ST_IDLE) && start && !abort;
    assign w_cnt_en    = (r_state == ST_EXEC);
    assign w_cnt_clear = abort || (r_state != ST_EXEC);

    iter_counter #(
        .W (w)
    ) u_iter_counter (
        .clk    (clk),
        .rst_b  (rst_b),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .cnt    (cnt),
        .tc     (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_op_q  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op_q <= op;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_next_state = ST_LOAD;
                ST_LOAD: w_next_state = is_iter_op(r_op_q) ? ST_EXEC : ST_DONE;
                ST_EXEC: if (w_tc) w_next_state = (r_op_q == OP_DIV) ? ST_FIX : ST_DONE;
                ST_FIX:  w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // All strobes decode from the registered state only.
    always_comb begin
        ld      = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        res_we  = 1'b0;
        done    = 1'b0;
        busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: ld = 1'b1;
            ST_EXEC: step_en = 1'b1;
            ST_FIX:  fix_en = 1'b1;
            ST_DONE: begin
                res_we = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel       = r_op_q;
    assign dbg_state = r_state;

endmodule
